// File: rtl/wb_router_8bit.sv
// wb_router_8bit: routes one ALU result to the register file, the data SRAM or I/O space.
// Holds the captured address and data steady for the whole write window.
module wb_router_8bit #(
  parameter int DATA_W     = 8,
  parameter int RF_ADDR_W  = 5,
  parameter int ADDR_W     = 8,
  parameter int MEM_WAIT   = 2,
  parameter int IO_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [ADDR_W-1:0]    in_addr,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 io_req,
  output logic [ADDR_W-1:0]    io_addr,
  output logic [DATA_W-1:0]    io_wdata,
  input  logic                 io_ack,
  output logic                 err_timeout
);
  typedef enum logic [1:0] {IDLE, RF_WR, MEM_WR, IO_WR} state_t;
  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_mcnt, w_mcnt;
  logic [7:0]          r_icnt, w_icnt;
  logic                r_err, w_err;
  logic                w_accept;
  assign in_ready    = (r_state == IDLE) & ~rst;
  assign w_accept    = in_valid & in_ready;
  assign rf_we       = r_state == RF_WR;
  assign mem_we      = r_state == MEM_WR;
  assign io_req      = r_state == IO_WR;
  assign rf_waddr    = r_addr[RF_ADDR_W-1:0];
  assign rf_wdata    = r_data;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_data;
  assign io_addr     = r_addr;
  assign io_wdata    = r_data;
  assign err_timeout = r_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_mcnt  <= '0;
      r_icnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mcnt  <= w_mcnt;
      r_icnt  <= w_icnt;
      r_err   <= w_err;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_data <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_addr <= in_addr;
    end
  // Counters load on accept and count down to zero; an ack on the last cycle wins over the timeout.
  always_comb begin
    w_next = r_state;
    w_mcnt = r_mcnt;
    w_icnt = r_icnt;
    w_err  = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_mcnt = 4'(MEM_WAIT - 1);
        w_icnt = 8'(IO_TIMEOUT - 1);
        w_next = in_sel == 2'b00 ? RF_WR : in_sel == 2'b10 ? MEM_WR : in_sel == 2'b01 ? IO_WR : IDLE;
      end
      RF_WR:  w_next = IDLE;
      MEM_WR: if (r_mcnt == 4'd0) w_next = IDLE; else w_mcnt = r_mcnt - 4'd1;
      IO_WR:  if (io_ack) w_next = IDLE;
              else if (r_icnt == 8'd0) begin
                w_next = IDLE;
                w_err  = 1'b1;
              end else w_icnt = r_icnt - 8'd1;
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_router_8bit.sv
// tb_wb_router_8bit: scenario tasks with inline checks plus a write-window scoreboard.
module tb_wb_router_8bit;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, io_ack = 1'b0;
  logic [1:0] in_sel = 2'b00;
  logic [7:0] in_data = '0, in_addr = '0;
  logic       in_ready, rf_we, mem_we, io_req, err_timeout;
  logic [4:0] rf_waddr;
  logic [7:0] rf_wdata, mem_addr, mem_wdata, io_addr, io_wdata;
  logic       in_ready4, rf_we4, mem_we4, io_req4, err_timeout4;
  logic [4:0] rf_waddr4;
  logic [7:0] rf_wdata4, mem_addr4, mem_wdata4, io_addr4, io_wdata4;
  int checks = 0, fails = 0;
  typedef struct packed {logic [1:0] kind; logic [7:0] addr; logic [7:0] data; int len;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_router_8bit #(.MEM_WAIT(2), .IO_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_data(in_data), .in_addr(in_addr), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .io_req(io_req),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_ack(io_ack), .err_timeout(err_timeout));

  wb_router_8bit #(.MEM_WAIT(4), .IO_TIMEOUT(15)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_sel(in_sel),
    .in_data(in_data), .in_addr(in_addr), .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .io_req(io_req4),
    .io_addr(io_addr4), .io_wdata(io_wdata4), .io_ack(io_ack), .err_timeout(err_timeout4));

  task automatic monitor();
    logic [1:0] k, ck;
    logic [7:0] a, d, ca, cd;
    int n = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_we | mem_we | io_req) begin
        checks++;
        if (int'(rf_we) + int'(mem_we) + int'(io_req) > 1) begin
          fails++;
          $display("FAIL exclusive: rf_we=%b mem_we=%b io_req=%b, required at most one high", rf_we, mem_we, io_req);
        end
        ck = rf_we ? 2'd0 : io_req ? 2'd1 : 2'd2;
        ca = rf_we ? {3'b000, rf_waddr} : io_req ? io_addr : mem_addr;
        cd = rf_we ? rf_wdata : io_req ? io_wdata : mem_wdata;
        if (n == 0) begin
          k = ck; a = ca; d = cd;
        end else begin
          checks++;
          if (ck !== k || ca !== a || cd !== d) begin
            fails++;
            $display("FAIL stable: kind/addr/data %0d/%h/%h, required %0d/%h/%h", ck, ca, cd, k, a, d);
          end
        end
        n++;
      end else if (n > 0) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: kind=%0d addr=%h data=%h len=%0d, required no write", k, a, d, n);
        end else begin
          e = sb.pop_front();
          if (e.kind !== k || e.addr !== a || e.data !== d || e.len !== n) begin
            fails++;
            $display("FAIL write: kind=%0d addr=%h data=%h len=%0d, required kind=%0d addr=%h data=%h len=%0d",
                     k, a, d, n, e.kind, e.addr, e.data, e.len);
          end
        end
        n = 0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, rf_we, mem_we, io_req, err_timeout} !== 5'b0 || mem_addr !== 8'h00 || rf_wdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: ready/rf/mem/io/err=%b%b%b%b%b addr=%h data=%h, required all 0",
               in_ready, rf_we, mem_we, io_req, err_timeout, mem_addr, rf_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_rf();
    in_valid = 1'b1; in_sel = 2'b00; in_addr = 8'h1F; in_data = 8'hA5;
    sb.push_back('{2'd0, 8'h1F, 8'hA5, 1});
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'h1F || rf_wdata !== 8'hA5 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rf_write: we=%b addr=%h data=%h ready=%b, required 1/1f/a5/0", rf_we, rf_waddr, rf_wdata, in_ready);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rf_done: we=%b ready=%b, required 0/1", rf_we, in_ready);
    end
  endtask

  task automatic test_mem();
    in_valid = 1'b1; in_sel = 2'b10; in_addr = 8'h40; in_data = 8'h3C;
    sb.push_back('{2'd2, 8'h40, 8'h3C, 2});
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 8'h3C || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL mem_write_c%0d: we=%b addr=%h data=%h ready=%b, required 1/40/3c/0", i, mem_we, mem_addr, mem_wdata, in_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (mem_we !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mem_done: we=%b ready=%b, required 0/1", mem_we, in_ready);
    end
  endtask

  // ack_at = cycle of io_req on which io_ack is raised; 0 means never
  task automatic test_io(input logic [7:0] a, input logic [7:0] d, input int ack_at);
    int len = ack_at == 0 ? 15 : ack_at;
    in_valid = 1'b1; in_sel = 2'b01; in_addr = a; in_data = d;
    sb.push_back('{2'd1, a, d, len});
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= len; i++) begin
      checks++;
      if (io_req !== 1'b1 || io_addr !== a || io_wdata !== d || err_timeout !== 1'b0) begin
        fails++;
        $display("FAIL io_req_c%0d: req=%b addr=%h data=%h err=%b, required 1/%h/%h/0", i, io_req, io_addr, io_wdata, err_timeout, a, d);
      end
      if (i == ack_at) io_ack = 1'b1;
      @(negedge clk);
    end
    io_ack = 1'b0;
    checks++;
    if (io_req !== 1'b0 || err_timeout !== (ack_at == 0) || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL io_end: req=%b err=%b ready=%b, required 0/%b/1", io_req, err_timeout, in_ready, ack_at == 0);
    end
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b0 || io_req !== 1'b0) begin
      fails++;
      $display("FAIL io_after: err=%b req=%b, required 0/0", err_timeout, io_req);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_sel = 2'b11;
    for (int i = 0; i < 4; i++) begin
      in_addr = 8'(i); in_data = 8'(8'h10 + i);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || {rf_we, mem_we, io_req} !== 3'b000) begin
        fails++;
        $display("FAIL discard_%0d: ready=%b strobes=%b, required 1/000", i, in_ready, {rf_we, mem_we, io_req});
      end
    end
    in_sel = 2'b00; in_addr = 8'hE3; in_data = 8'h5E;
    sb.push_back('{2'd0, 8'h03, 8'h5E, 1});
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'h03 || rf_wdata !== 8'h5E) begin
      fails++;
      $display("FAIL rf_after_discard: we=%b addr=%h data=%h, required 1/03/5e", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    repeat (20) @(negedge clk);
    checks++;
    if (in_ready4 !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre_idle: ready4=%b ready=%b, required 1/1", in_ready4, in_ready);
    end
    in_valid = 1'b1; in_sel = 2'b10; in_addr = 8'h77; in_data = 8'h5A;
    sb.push_back('{2'd2, 8'h77, 8'h5A, 1});
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mem_we4 !== 1'b1 || mem_addr4 !== 8'h77) begin
      fails++;
      $display("FAIL abort_start: we=%b addr=%h, required 1/77", mem_we4, mem_addr4);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_we4 !== 1'b0 || mem_we !== 1'b0 || in_ready4 !== 1'b0 || mem_addr4 !== 8'h00) begin
      fails++;
      $display("FAIL abort_drop: we4=%b we=%b ready4=%b addr4=%h, required 0/0/0/00", mem_we4, mem_we, in_ready4, mem_addr4);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (mem_we4 !== 1'b0 || {rf_we4, io_req4} !== 2'b00 || in_ready4 !== 1'b1) begin
        fails++;
        $display("FAIL abort_after_c%0d: we4=%b rf4/io4=%b ready4=%b, required 0/00/1", i, mem_we4, {rf_we4, io_req4}, in_ready4);
      end
    end
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_rf();
    test_mem();
    test_io(8'h3F, 8'h81, 3);
    test_io(8'hC2, 8'h4D, 0);
    test_io(8'h07, 8'hE8, 15);
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
